// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the UART-driven memory loader.
// Data words arrive big-endian: high byte first, then low byte.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_CNT_H,
        ST_CNT_L,
        ST_DAT_H,
        ST_DAT_L,
        ST_WRITE
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;

    // States that wait on the byte stream inside a command and so may time out.
    function automatic logic timeout_active(input state_t s);
        return s inside {ST_ADDR_H, ST_ADDR_L, ST_CNT_H, ST_CNT_L, ST_DAT_H, ST_DAT_L};
    endfunction

endpackage

// File: rtl/mem_loader_timeout.sv
// Inter-byte idle counter: cleared on every accepted byte, saturates at TIMEOUT.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_loader.sv
// Byte-stream write-command decoder feeding the 16-bit block memory; owns the
// memory bus and holds the CPU in reset while a command is in progress.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [7:0]    i_rx_dat,
    input  logic          i_rx_valid,
    output logic          o_rx_ready,
    input  logic [15:0]   i_cpu_dat,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic          i_cpu_we,
    input  logic          i_cpu_cyc,
    output logic [15:0]   o_mem_dat,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic          o_mem_cyc,
    output logic          o_cpu_reset,
    output logic          o_busy,
    output logic          o_err
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    lo_q, lo_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          err_q, err_d;
    logic          rx_take;
    logic          tmo_enable;
    logic          tmo_expired;

    assign rx_take    = i_rx_valid && o_rx_ready;
    assign tmo_enable = timeout_active(state_q);

    loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .clear   (rx_take),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cpu_reset_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cpu_reset_q <= cpu_reset_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_take) begin
                    if (i_rx_dat == CMD_WRITE) state_d = ST_ADDR_H;
                    else                       err_d   = 1'b1;
                end
            end
            // ADDR_H leaves the low byte zero, so ADDR_L can simply OR it in.
            ST_ADDR_H: if (rx_take) begin
                addr_d  = AW'({i_rx_dat, 8'h00});
                state_d = ST_ADDR_L;
            end
            ST_ADDR_L: if (rx_take) begin
                addr_d  = addr_q | AW'(i_rx_dat);
                state_d = ST_CNT_H;
            end
            ST_CNT_H: if (rx_take) begin
                cnt_d   = {i_rx_dat, 8'h00};
                state_d = ST_CNT_L;
            end
            ST_CNT_L: if (rx_take) begin
                cnt_d   = {cnt_q[15:8], i_rx_dat};
                state_d = ({cnt_q[15:8], i_rx_dat} == 16'h0000) ? ST_IDLE : ST_DAT_H;
            end
            ST_DAT_H: if (rx_take) begin
                hi_d    = i_rx_dat;
                state_d = ST_DAT_L;
            end
            ST_DAT_L: if (rx_take) begin
                lo_d    = i_rx_dat;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d  = addr_q + AW'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_DAT_H;
            end
            default: state_d = ST_IDLE;
        endcase
        // A byte arriving in the expiry cycle takes priority over the abort.
        if (tmo_enable && tmo_expired && !rx_take) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
        cpu_reset_d = (state_d != ST_IDLE);
    end

    always_comb begin
        o_rx_ready  = (state_q != ST_WRITE);
        o_busy      = (state_q != ST_IDLE);
        o_cpu_reset = cpu_reset_q;
        o_err       = err_q;
        o_mem_dat   = {hi_q, lo_q};
        o_mem_addr  = addr_q;
        o_mem_we    = 1'b0;
        o_mem_cyc   = 1'b0;
        if (state_q == ST_IDLE) begin
            o_mem_dat  = i_cpu_dat;
            o_mem_addr = i_cpu_addr;
            o_mem_we   = i_cpu_we;
            o_mem_cyc  = i_cpu_cyc;
        end else if (state_q == ST_WRITE) begin
            o_mem_we  = 1'b1;
            o_mem_cyc = 1'b1;
        end
    end

endmodule
